axi_w_burst_gen: RTL
====================

// Module: axi_w_burst_gen
// PURPOSE
//  AXI4 write-channel initiator (AW/W/B master). On cfg_start it issues cfg_num
//  sequential INCR bursts of cfg_len+1 full 64-byte beats, then sets done. Drives
//  any axi_bus_W_t slave port (write sinks, DDR write path) for bring-up and bandwidth tests.
//  Single outstanding burst; the first non-OKAY write response is captured.
// PARAMETERS
//  BEAT_BYTES  64   bytes per beat; fixes awsize=6 and the address stride
// PORTS
//  clk          in   1    clock; all logic on rising edge
//  rst          in   1    synchronous, active-high reset
//  cfg_start    in   1    1-cycle request; sampled only in IDLE
//  cfg_addr     in   64   first burst address; BEAT_BYTES aligned
//  cfg_len      in   8    beats per burst minus 1 (AXI awlen)
//  cfg_num      in   16   number of bursts; 0 is legal
//  cfg_id       in   6    awid for every burst
//  cfg_seed     in   32   data pattern seed
//  busy         out  1    high from accepted start until done pulse
//  done         out  1    1-cycle pulse: run complete
//  err          out  1    sticky: some bresp != 0 this run
//  err_resp     out  2    first non-zero bresp this run
//  bursts_done  out  16   B responses accepted this run
//  awid/awaddr/awlen/awsize/awvalid out 6/64/8/3/1; awready in 1
//  wdata/wstrb/wlast/wvalid out 512/64/1/1; wready in 1
//  bid/bresp/bvalid in 6/2/1; bready out 1
// BEHAVIOUR
//  Reset: state IDLE; every valid/ready output, busy, done, err, err_resp,
//   bursts_done = 0; awid/awaddr/awlen/wdata = 0; wstrb = all-ones. Reset mid-burst
//   drops awvalid/wvalid at that edge (the only allowed valid retraction).
//  States: IDLE -> ISSUE -> WAIT_B -> ISSUE | FINISH -> IDLE.
//  IDLE: cfg_start latches cfg_*; clears err, err_resp, bursts_done; sets busy.
//   cfg_num==0 -> FINISH; else ISSUE. cfg_start outside IDLE is ignored.
//  ISSUE: awvalid and wvalid both assert the first cycle in ISSUE (one cycle after
//   start). They stay high, with stable payload, until their handshakes.
//   aw_sent flag is set on awvalid&&awready, then awvalid drops.
//   W beat counter increments per wvalid&&wready; wlast = (beat==len).
//   W may complete before AW. Leave ISSUE when aw_sent and last beat have both
//   handshaken, including the same cycle.
//  WAIT_B: bready=1 only here. On bvalid: bursts_done++.
//   If bresp!=0 and !err: err=1, err_resp=bresp.
//   bid is not checked. Next: ISSUE if bursts_done+1 < num, else FINISH.
//  FINISH: done=1 and busy=0 for one cycle -> IDLE.
//  Payload: awaddr(k) = cfg_addr + k*(len+1)*BEAT_BYTES (mod 2^64, 4KB crossing not
//   prevented); awsize=6; wstrb all-ones.
//  Data: wdata = {16{pat}}; pat starts at cfg_seed and increments by 1 per accepted
//   beat across all bursts, wrapping at 2^32.
//  Throughput: 1 beat/cycle while wready=1.
//   Min burst cost = len+1 cycles in ISSUE + 1 in WAIT_B.
// TESTING
//  addr=0x1000,len=0,num=1,seed=5, ready tied 1 -> AW/W at cycle 1 (wlast=1, pat 5), bready cycle 2, done cycle 3
//  len=3,num=2,addr=0x0 -> awaddr 0x0 then 0x100; pats 0..7; wlast on beats 3,7; bursts_done=2
//  awready held 0 for 10 cycles while wready=1 -> all W beats first, AW payload stable, no early B wait
//  bresp sequence 0,2,3 on num=3 -> err=1, err_resp=2, run still completes with bursts_done=3
//  num=0 -> no valids, done pulse 2 cycles after start; start during busy ignored
//  rst asserted mid-W (beat 2 of 4) -> next cycle all valids 0, IDLE; a fresh run is clean

Source files
------------

// File: rtl/axi_w_burst_gen.sv
// AXI4 write-channel burst initiator: issues cfg_num INCR bursts of cfg_len+1 full beats,
// one burst outstanding at a time, and records the first error response of the run.
module axi_w_burst_gen #(
    parameter int unsigned BEAT_BYTES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic [63:0]               cfg_addr,
    input  logic [7:0]                cfg_len,
    input  logic [15:0]               cfg_num,
    input  logic [5:0]                cfg_id,
    input  logic [31:0]               cfg_seed,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                err_resp,
    output logic [15:0]               bursts_done,
    output logic [5:0]                awid,
    output logic [63:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [BEAT_BYTES*8-1:0]   wdata,
    output logic [BEAT_BYTES-1:0]     wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [5:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);
    localparam int unsigned SIZE = $clog2(BEAT_BYTES);
    localparam int unsigned PATS = BEAT_BYTES / 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, FINISH} state_t;

    state_t      state;
    logic [7:0]  len_q;
    logic [15:0] num_q;
    logic [31:0] pat;
    logic [7:0]  beat;
    logic        aw_sent;
    logic        w_done;
    logic [63:0] stride;
    logic        aw_hs;
    logic        w_hs;
    logic        unused_bid;

    assign awsize     = 3'(SIZE);
    assign wstrb      = '1;
    assign stride     = (64'(len_q) + 64'd1) << SIZE;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign unused_bid = ^bid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_resp    <= '0;
            bursts_done <= '0;
            awid        <= '0;
            awaddr      <= '0;
            awlen       <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wlast       <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            len_q       <= '0;
            num_q       <= '0;
            pat         <= '0;
            beat        <= '0;
            aw_sent     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cfg_start) begin
                        len_q       <= cfg_len;
                        num_q       <= cfg_num;
                        awid        <= cfg_id;
                        awlen       <= cfg_len;
                        awaddr      <= cfg_addr;
                        pat         <= cfg_seed;
                        wdata       <= {PATS{cfg_seed}};
                        beat        <= '0;
                        wlast       <= (cfg_len == 8'd0);
                        aw_sent     <= 1'b0;
                        w_done      <= 1'b0;
                        err         <= 1'b0;
                        err_resp    <= '0;
                        bursts_done <= '0;
                        busy        <= 1'b1;
                        if (cfg_num == 16'd0) begin
                            state <= FINISH;
                        end else begin
                            state   <= ISSUE;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_sent <= 1'b1;
                    end
                    if (w_hs) begin
                        pat   <= pat + 32'd1;
                        wdata <= {PATS{pat + 32'd1}};
                        beat  <= beat + 8'd1;
                        wlast <= (beat + 8'd1 == len_q);
                        if (wlast) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                    end
                    // AW and the final W beat may complete in either order or together
                    if ((aw_sent || aw_hs) && (w_done || (w_hs && wlast))) begin
                        state  <= WAIT_B;
                        bready <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (bvalid) begin
                        bready      <= 1'b0;
                        bursts_done <= bursts_done + 16'd1;
                        if (bresp != 2'b00 && !err) begin
                            err      <= 1'b1;
                            err_resp <= bresp;
                        end
                        if (bursts_done + 16'd1 < num_q) begin
                            state   <= ISSUE;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= awaddr + stride;
                            beat    <= '0;
                            wlast   <= (len_q == 8'd0);
                            aw_sent <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    // An empty run arrives here with done low, so it spends one busy
                    // cycle before pulsing done; a completed run arrives with done set.
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
